bias_accum_stage: RTL
=====================

Name: bias_accum_stage

Overview:
- Consumer of the packed per-layer bias bus driven by the BIAS constant banks (N_adder_tree lanes × 18-bit two's-complement).
- Accumulates N_PASSES partial-sum beats per output channel lane from the adder tree and adds the lane bias once.
- Applies saturation to 18 bits and optional ReLU.
- Presents the result on a valid/ready stream to the next layer buffer.

Parameters:
- N_adder_tree, 16, number of parallel lanes; this is also the bias bus lane count.
- DATA_W, 18, lane width for the bias, input and output buses.
- ACC_W, 24, internal accumulator width. It must satisfy ACC_W >= DATA_W + clog2(N_PASSES+1); an elaboration-time check enforces this.
- N_PASSES, 4, number of input beats per result. It must be >= 1.
- RELU_EN, 1, when 1, negative saturated results output 0.

Ports:
- clk, input, 1, clock. All logic is on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- bias_in, input, N_adder_tree*DATA_W, packed bias bus. Lane i is bias_in[DATA_W*(i+1)-1 : DATA_W*i]. It is quasi-static.
- in_valid, input, 1, partial-sum beat valid.
- in_ready, output, 1, stage can accept a beat.
- in_data, input, N_adder_tree*DATA_W, packed signed partial sums. It uses the same lane packing as bias_in.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- out_data, output, N_adder_tree*DATA_W, packed saturated results.
- pass_cnt, output, clog2(N_PASSES) (min 1), index of the next beat to be accepted.

Behaviour:
- Reset: one clk with rst=1 clears everything, including mid-accumulation.
  - pass_cnt=0, all accumulators=0, out_valid=0, out_data=0.
  - in_ready=1 the cycle after reset.
  - A partially accumulated result is discarded and is never output.
- Beat accepted: in_valid && in_ready.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - out_valid/out_data are registered and hold stable while out_valid && !out_ready.
- Lane arithmetic: all operands are sign-extended to ACC_W. Accumulator wrap is impossible given the ACC_W constraint.
  - First beat (pass_cnt==0): acc <= sext(in) + sext(bias).
  - Middle beats: acc <= acc + sext(in).
  - Last beat (pass_cnt==N_PASSES-1): final = acc + sext(in), or sext(in) + sext(bias) when N_PASSES==1.
    - sat(final) clamps to [-131072, 131071] for DATA_W=18, i.e. [-2^(DATA_W-1), 2^(DATA_W-1)-1].
    - If RELU_EN, negative values become 0.
    - The result is registered into out_data, out_valid <= 1 and pass_cnt <= 0.
- pass_cnt increments on each accepted non-last beat and wraps to 0 on the last.
- Latency: out_valid rises on the clk edge after the last beat is accepted, i.e. 1 cycle.
- Simultaneous events:
  - If the last beat is accepted in the same cycle an old result is taken (out_valid && out_ready), out_data loads the new result and out_valid stays 1.
  - If out_ready=1 with no last beat, out_valid <= 0.
- Full throughput: one result per N_PASSES cycles with no bubbles when in_valid=1 and out_ready=1 continuously.
- Sampling rules:
  - bias_in is sampled only on the first beat of each result. A change mid-result affects only the next result.
  - in_data is ignored when not accepted.
- Control: pass_cnt and the control FSM are shared across all lanes. There is no per-lane control.

Decomposition:
- Shared package (cnn_pkg):
  - DATA_W default and the SAT_MAX/SAT_MIN constants.
  - Functions sext_acc() and sat_relu(value, relu_en).
- Sub-module bias_accum_lane, instantiated N_adder_tree times via generate.
  - It holds one ACC_W accumulator plus the sat/ReLU output register.
  - It takes first/last/accept strobes from the parent.
- The parent holds pass_cnt, the valid/ready logic and the lane slicing.

Test Plan:
1. Reset mid-result: accept 2 beats, then rst=1 for 1 cycle. Require out_valid=0, out_data=0, pass_cnt=0, in_ready=1. Then 4 fresh beats with in=10 and bias=100 give 140 per lane, with no contribution from the aborted beats.
2. Basic: RELU_EN=0, all lanes bias=100, 4 beats of in=10, out_ready=1. Require out_valid=1 exactly 1 cycle after the 4th accept, all lanes=140, and out_valid=0 the following cycle.
3. Saturation and ReLU: bias=131000 with beats of 50 ×4 gives 131071. bias=-131000 with beats of -50 ×4 gives -131072 when RELU_EN=0 and 0 when RELU_EN=1.
4. Backpressure: hold out_ready=0 after a result. Require out_valid=1, out_data stable and in_ready=0 for 5 cycles. Raising out_ready with in_valid=1 makes in_ready=1 and accepts the next beat in that same cycle.
5. Throughput: continuous in_valid=1, out_ready=1, in=1, bias=0 for 12 beats. Require results on cycles 5, 9 and 13 after the first accept, each lane=4, with no stalls.
6. Lane independence: lane i has bias=-i and in=i for 4 beats. Require lane i output=3i for i=0..15, confirming correct lane slicing and packing order.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cnn_pkg
// Description : Shared lane width, saturation limits and lane arithmetic
//               helpers for the CNN datapath stages.
// Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    // Default lane width of the bias, partial-sum and result buses
    localparam int DATA_W = 18;

    // Helpers work on a wide signed type so any accumulator up to this width fits
    localparam int WIDE_W = 64;

    localparam logic signed [WIDE_W-1:0] SAT_MAX = (64'sd1 <<< (DATA_W - 1)) - 64'sd1;
    localparam logic signed [WIDE_W-1:0] SAT_MIN = -(64'sd1 <<< (DATA_W - 1));

    // Sign-extend one lane value to the wide helper type
    function automatic logic signed [WIDE_W-1:0] sext_acc(input logic signed [DATA_W-1:0] v);
        return WIDE_W'(v);
    endfunction

    // Clamp to the lane range, then optionally zero negative results
    function automatic logic signed [WIDE_W-1:0] sat_relu(
        input logic signed [WIDE_W-1:0] value,
        input logic                     relu_en
    );
        logic signed [WIDE_W-1:0] r;
        if (value > SAT_MAX) begin
            r = SAT_MAX;
        end else if (value < SAT_MIN) begin
            r = SAT_MIN;
        end else begin
            r = value;
        end
        if (relu_en && (r < 0)) begin
            r = '0;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bias_accum_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : bias_accum_stage_if
// Description : Bias bus, partial-sum input stream and result output stream
//               of the bias accumulation stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface bias_accum_stage_if #(
    parameter int N_LANES = 16,
    parameter int DATA_W  = 18,
    parameter int PASS_W  = 2
);
    logic [N_LANES*DATA_W-1:0] bias_in;
    logic                      in_valid;
    logic                      in_ready;
    logic [N_LANES*DATA_W-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [N_LANES*DATA_W-1:0] out_data;
    logic [PASS_W-1:0]         pass_cnt;

    modport master (
        output bias_in, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, pass_cnt
    );

    modport slave (
        input  bias_in, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, pass_cnt
    );
endinterface
`default_nettype wire

// File: rtl/bias_accum_lane.sv
`default_nettype none
// ============================================================================
// Module      : bias_accum_lane
// Description : One lane of the bias accumulator: ACC_W running sum plus the
//               saturated / ReLU result register.
// Revision    : 1.0 - initial release
// ============================================================================
module bias_accum_lane
    import cnn_pkg::*;
#(
    parameter int DATA_W  = cnn_pkg::DATA_W,
    parameter int ACC_W   = 24,
    parameter int RELU_EN = 1
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_first,
    input  wire logic                     i_last,
    input  wire logic                     i_accept,
    input  wire logic signed [DATA_W-1:0] i_bias,
    input  wire logic signed [DATA_W-1:0] i_data,
    output      logic signed [DATA_W-1:0] o_data
);

    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] out_q, out_d;
    logic signed [ACC_W-1:0]  w_in_ext, w_bias_ext, w_sum;

    // Next accumulator / result: bias enters with the first beat only
    always_comb begin
        w_in_ext   = ACC_W'(sext_acc(i_data));
        w_bias_ext = ACC_W'(sext_acc(i_bias));
        w_sum      = i_first ? (w_in_ext + w_bias_ext) : (acc_q + w_in_ext);
        acc_d      = acc_q;
        out_d      = out_q;
        if (i_accept) begin
            acc_d = i_last ? '0 : w_sum;
            if (i_last) begin
                out_d = DATA_W'(sat_relu(WIDE_W'(w_sum), RELU_EN != 0));
            end
        end
    end

    // Lane state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign o_data = out_q;

endmodule
`default_nettype wire

// File: rtl/bias_accum_stage.sv
`default_nettype none
// ============================================================================
// Module      : bias_accum_stage
// Description : Accumulates N_PASSES partial-sum beats per lane, adds the
//               lane bias once, saturates (optional ReLU) and streams the
//               result out on a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module bias_accum_stage
    import cnn_pkg::*;
#(
    parameter int N_adder_tree = 16,
    parameter int DATA_W       = cnn_pkg::DATA_W,
    parameter int ACC_W        = 24,
    parameter int N_PASSES     = 4,
    parameter int RELU_EN      = 1
) (
    input wire logic          clk,
    input wire logic          rst,
    bias_accum_stage_if.slave bus
);

    localparam int PASS_W = (N_PASSES > 1) ? $clog2(N_PASSES) : 1;
    localparam logic [PASS_W-1:0] c_last_pass = PASS_W'(N_PASSES - 1);

    // Elaboration-time parameter sanity
    if (N_PASSES < 1) begin : g_bad_passes
        $error("bias_accum_stage: N_PASSES must be >= 1");
    end
    if (ACC_W < DATA_W + $clog2(N_PASSES + 1)) begin : g_bad_acc_w
        $error("bias_accum_stage: ACC_W too narrow for DATA_W and N_PASSES");
    end
    if (ACC_W > WIDE_W) begin : g_bad_acc_wide
        $error("bias_accum_stage: ACC_W exceeds helper width");
    end
    if (DATA_W != cnn_pkg::DATA_W) begin : g_bad_data_w
        $error("bias_accum_stage: DATA_W must match cnn_pkg::DATA_W");
    end

    logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              w_in_ready, w_accept, w_first, w_last;

    // Shared control: beat acceptance, pass counter and output valid
    always_comb begin
        w_in_ready  = !out_valid_q || bus.out_ready;
        w_accept    = bus.in_valid && w_in_ready;
        w_first     = (pass_cnt_q == '0);
        w_last      = (pass_cnt_q == c_last_pass);
        pass_cnt_d  = pass_cnt_q;
        out_valid_d = out_valid_q;
        if (out_valid_q && bus.out_ready) begin
            out_valid_d = 1'b0;
        end
        if (w_accept) begin
            if (w_last) begin
                pass_cnt_d  = '0;
                out_valid_d = 1'b1;
            end else begin
                pass_cnt_d = pass_cnt_q + 1'b1;
            end
        end
    end

    // Control state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pass_cnt_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            pass_cnt_q  <= pass_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
        bias_accum_lane #(
            .DATA_W  (DATA_W),
            .ACC_W   (ACC_W),
            .RELU_EN (RELU_EN)
        ) u_lane (
            .clk      (clk),
            .rst      (rst),
            .i_first  (w_first),
            .i_last   (w_last),
            .i_accept (w_accept),
            .i_bias   (bus.bias_in[DATA_W*i +: DATA_W]),
            .i_data   (bus.in_data[DATA_W*i +: DATA_W]),
            .o_data   (bus.out_data[DATA_W*i +: DATA_W])
        );
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.pass_cnt  = pass_cnt_q;

endmodule
`default_nettype wire
